// File: rtl/tcs3200_pkg.sv
// rtl/tcs3200_pkg.sv - shared filter/colour encodings and FSM state type for the TCS3200 classifier
package tcs3200_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEAS_G,
    ST_MEAS_R,
    ST_MEAS_B,
    ST_DECIDE
  } state_t;

  // S2S3 photodiode select
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // Classification result
  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;

  // Filter the sensor must be looking through in each state
  function automatic logic [1:0] filter_for(input state_t s);
    case (s)
      ST_MEAS_G: filter_for = FILT_GREEN;
      ST_MEAS_R: filter_for = FILT_RED;
      ST_MEAS_B: filter_for = FILT_BLUE;
      default:   filter_for = FILT_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/cs_edge_sync.sv
// rtl/cs_edge_sync.sv - two-flop synchroniser and registered rising-edge detector for cs_out
module cs_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;

  // Synchronise the async input, then flag a 0->1 transition one flop later
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= cs_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tcs3200_color_classifier.sv
// rtl/tcs3200_color_classifier.sv - sequences G/R/B filter phases, counts cs_out edges and classifies colour
module tcs3200_color_classifier #(
  parameter int PHASE_CYCLES  = 500,
  parameter int WINDOW_CYCLES = 100,
  parameter int CNT_W         = 8,
  parameter int MIN_COUNT     = 2
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic             cs_out,
  input  logic             start,
  input  logic             continuous,
  output logic [1:0]       filter,
  output logic [1:0]       color,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  import tcs3200_pkg::*;

  localparam int PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(PHASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  WIN_START = PH_W'(PHASE_CYCLES - WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [1:0]       color_q, color_d;
  logic [CNT_W-1:0] rc_q, rc_d, gc_q, gc_d, bc_q, bc_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_hit;
  logic [1:0]       win_color;
  logic [CNT_W-1:0] win_max;

  cs_edge_sync u_sync (
    .clk_i  (clk_1MHz),
    .rst_ni (rst_n),
    .cs_i   (cs_out),
    .rise_o (rise)
  );

  // Window counter next value: only edges late in the phase count, saturating at all-ones
  always_comb begin
    cnt_next = cnt_q;
    sat_hit  = 1'b0;
    if (rise && (phase_q >= WIN_START)) begin
      if (cnt_q == CNT_MAX) begin
        sat_hit = 1'b1;
      end else begin
        cnt_next = cnt_q + CNT_W'(1);
      end
    end
  end

  // Winner selection: strongest channel, ties favour red, then green
  always_comb begin
    win_color = COLOR_RED;
    win_max   = r_q;
    if ((r_q >= g_q) && (r_q >= b_q)) begin
      win_color = COLOR_RED;
      win_max   = r_q;
    end else if (g_q >= b_q) begin
      win_color = COLOR_GREEN;
      win_max   = g_q;
    end else begin
      win_color = COLOR_BLUE;
      win_max   = b_q;
    end
    if (int'(win_max) < MIN_COUNT) begin
      win_color = COLOR_NONE;
    end
  end

  // Sequencer next-state, phase timing, channel latching and result update
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    color_d = color_q;
    rc_d    = rc_q;
    gc_d    = gc_q;
    bc_d    = bc_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = ST_MEAS_G;
          sat_d   = 1'b0;
        end
      end
      ST_MEAS_G, ST_MEAS_R, ST_MEAS_B: begin
        sat_d = sat_q | sat_hit;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          cnt_d   = '0;
          case (state_q)
            ST_MEAS_G: begin g_d = cnt_next; state_d = ST_MEAS_R;  end
            ST_MEAS_R: begin r_d = cnt_next; state_d = ST_MEAS_B;  end
            default:   begin b_d = cnt_next; state_d = ST_DECIDE;  end
          endcase
        end else begin
          phase_d = phase_q + PH_W'(1);
          cnt_d   = cnt_next;
        end
      end
      ST_DECIDE: begin
        color_d = win_color;
        rc_d    = r_q;
        gc_d    = g_q;
        bc_d    = b_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        phase_d = '0;
        cnt_d   = '0;
        if (continuous) begin
          state_d = ST_MEAS_G;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      color_q <= COLOR_NONE;
      rc_q    <= '0;
      gc_q    <= '0;
      bc_q    <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      color_q <= color_d;
      rc_q    <= rc_d;
      gc_q    <= gc_d;
      bc_q    <= bc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign filter      = filter_for(state_q);
  assign busy        = (state_q != ST_IDLE);
  assign color       = color_q;
  assign red_count   = rc_q;
  assign green_count = gc_q;
  assign blue_count  = bc_q;
  assign overflow    = ovf_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_tcs3200_color_classifier.sv
// tb/tb_tcs3200_color_classifier.sv - directed self-checking bench for tcs3200_color_classifier
`timescale 1ns/1ps
module tb_tcs3200_color_classifier;

  logic       clk = 1'b0;
  logic       rst_n, cs_out, start, continuous;
  logic [1:0] filter, color;
  logic [7:0] red_count, green_count, blue_count;
  logic       valid, busy, overflow;

  logic       cs4 = 1'b0, start4;
  logic [1:0] filter4, color4;
  logic [3:0] red4, green4, blue4;
  logic       valid4, busy4, overflow4;

  int checks = 0;
  int failures = 0;

  int p_r = 10, p_g = 20, p_b = 25, p_c = 7;
  int tcnt = 0;
  logic [1:0] last_f = 2'b10;

  always #500 clk = ~clk;

  tcs3200_color_classifier dut (
    .clk_1MHz(clk), .rst_n(rst_n), .cs_out(cs_out), .start(start), .continuous(continuous),
    .filter(filter), .color(color), .red_count(red_count), .green_count(green_count),
    .blue_count(blue_count), .valid(valid), .busy(busy), .overflow(overflow)
  );

  tcs3200_color_classifier #(.CNT_W(4)) dut4 (
    .clk_1MHz(clk), .rst_n(rst_n), .cs_out(cs4), .start(start4), .continuous(1'b0),
    .filter(filter4), .color(color4), .red_count(red4), .green_count(green4),
    .blue_count(blue4), .valid(valid4), .busy(busy4), .overflow(overflow4)
  );

  // Sensor model: square wave whose period (in cycles) follows the selected filter
  always @(negedge clk) begin
    int per;
    case (filter)
      2'b00:   per = p_r;
      2'b01:   per = p_b;
      2'b11:   per = p_g;
      default: per = p_c;
    endcase
    if (filter !== last_f) begin
      tcnt   = 0;
      last_f = filter;
    end else begin
      tcnt = (tcnt + 1 >= per) ? 0 : tcnt + 1;
    end
    cs_out = (tcnt < per / 2);
    cs4    = ~cs4;
  end

  initial begin
    #60000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(input int n0, input int limit, output int at);
    int n = n0;
    at = -1;
    while (n <= limit && at < 0) begin
      if (valid === 1'b1) at = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; start4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (filter !== 2'b10) begin failures++; $display("FAIL reset_filter got=%b exp=10", filter); end
    checks++; if (color !== 2'd0) begin failures++; $display("FAIL reset_color got=%0d exp=0", color); end
    checks++; if ({red_count, green_count, blue_count} !== 24'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0", red_count, green_count, blue_count); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Red-dominant run with filter sequence and latency checked along the way
  task automatic test_red();
    int at = -1;
    p_r = 10; p_g = 20; p_b = 25;
    do_start();
    for (int n = 0; n <= 1600 && at < 0; n++) begin
      if (n == 0) begin
        checks++; if (filter !== 2'b11) begin failures++; $display("FAIL red_filter_g got=%b exp=11", filter); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL red_busy got=%b exp=1", busy); end
      end
      if (n == 500) begin
        checks++; if (filter !== 2'b00) begin failures++; $display("FAIL red_filter_r got=%b exp=00", filter); end
      end
      if (n == 1000) begin
        checks++; if (filter !== 2'b01) begin failures++; $display("FAIL red_filter_b got=%b exp=01", filter); end
      end
      if (n == 1500) begin
        checks++; if (filter !== 2'b10) begin failures++; $display("FAIL red_filter_decide got=%b exp=10", filter); end
      end
      if (valid === 1'b1) at = n;
      else @(negedge clk);
    end
    checks++; if (at < 1501 || at > 1502) begin failures++; $display("FAIL red_latency got=%0d exp=1501..1502", at); end
    checks++; if (color !== 2'd1) begin failures++; $display("FAIL red_color got=%0d exp=1", color); end
    checks++; if (red_count < 9 || red_count > 11) begin failures++; $display("FAIL red_rcount got=%0d exp=10+-1", red_count); end
    checks++; if (green_count < 4 || green_count > 6) begin failures++; $display("FAIL red_gcount got=%0d exp=5+-1", green_count); end
    checks++; if (blue_count < 3 || blue_count > 5) begin failures++; $display("FAIL red_bcount got=%0d exp=4+-1", blue_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL red_overflow got=%b exp=0", overflow); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL red_valid_width got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL red_idle_busy got=%b exp=0", busy); end
  endtask

  // Generic colour scenario: periods in, colour and counts (+-1) expected
  task automatic run_colour(input string tag, input int pr, input int pg, input int pb,
                            input logic [1:0] exp_col, input int er, input int eg, input int eb);
    int at;
    p_r = pr; p_g = pg; p_b = pb;
    do_start();
    wait_valid(0, 1600, at);
    checks++; if (at < 1501 || at > 1502) begin failures++; $display("FAIL %s_latency got=%0d exp=1501..1502", tag, at); end
    checks++; if (color !== exp_col) begin failures++; $display("FAIL %s_color got=%0d exp=%0d", tag, color, exp_col); end
    checks++; if (int'(red_count) < er - 1 || int'(red_count) > er + 1) begin failures++; $display("FAIL %s_rcount got=%0d exp=%0d+-1", tag, red_count, er); end
    checks++; if (int'(green_count) < eg - 1 || int'(green_count) > eg + 1) begin failures++; $display("FAIL %s_gcount got=%0d exp=%0d+-1", tag, green_count, eg); end
    checks++; if (int'(blue_count) < eb - 1 || int'(blue_count) > eb + 1) begin failures++; $display("FAIL %s_bcount got=%0d exp=%0d+-1", tag, blue_count, eb); end
    @(negedge clk);
  endtask

  task automatic test_green();
    run_colour("green", 50, 8, 50, 2'd2, 2, 12, 2);
  endtask

  task automatic test_blue();
    run_colour("blue", 40, 40, 5, 2'd3, 2, 2, 20);
  endtask

  task automatic test_tie();
    run_colour("tie", 8, 8, 33, 2'd1, 12, 12, 3);
    checks++; if (red_count !== green_count) begin failures++; $display("FAIL tie_equal got=%0d/%0d exp=equal", red_count, green_count); end
  endtask

  task automatic test_none();
    run_colour("none", 100, 100, 100, 2'd0, 1, 1, 1);
  endtask

  task automatic test_overflow();
    int at = -1;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int n = 0; n <= 1600 && at < 0; n++) begin
      if (valid4 === 1'b1) at = n;
      else @(negedge clk);
    end
    checks++; if (at < 1501 || at > 1502) begin failures++; $display("FAIL ovf_latency got=%0d exp=1501..1502", at); end
    checks++; if ({red4, green4, blue4} !== 12'hFFF) begin failures++; $display("FAIL ovf_counts got=%0d/%0d/%0d exp=15", red4, green4, blue4); end
    checks++; if (overflow4 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow4); end
    checks++; if (color4 !== 2'd1) begin failures++; $display("FAIL ovf_color got=%0d exp=1", color4); end
  endtask

  task automatic test_continuous();
    int vpos[3] = '{-1, -1, -1};
    int vcnt = 0;
    p_r = 10; p_g = 20; p_b = 25;
    continuous = 1'b1;
    do_start();
    for (int n = 0; n <= 4800; n++) begin
      if (n == 3100) continuous = 1'b0;
      if (valid === 1'b1) begin
        if (vcnt < 3) vpos[vcnt] = n;
        vcnt++;
      end
      if (n == 1501) begin
        checks++; if (filter !== 2'b11) begin failures++; $display("FAIL cont_filter_g got=%b exp=11", filter); end
      end
      if (n == 2001) begin
        checks++; if (filter !== 2'b00) begin failures++; $display("FAIL cont_filter_r got=%b exp=00", filter); end
      end
      if (n == 2501) begin
        checks++; if (filter !== 2'b01) begin failures++; $display("FAIL cont_filter_b got=%b exp=01", filter); end
      end
      if (n == 3001) begin
        checks++; if (filter !== 2'b10) begin failures++; $display("FAIL cont_filter_decide got=%b exp=10", filter); end
      end
      if (n == 4503) begin
        checks++; if (busy !== 1'b0 || filter !== 2'b10) begin failures++; $display("FAIL cont_stop got busy=%b filter=%b exp busy=0 filter=10", busy, filter); end
      end
      @(negedge clk);
    end
    checks++; if (vcnt != 3) begin failures++; $display("FAIL cont_valid_count got=%0d exp=3", vcnt); end
    checks++; if (vpos[0] != 1501 || vpos[1] != 3002 || vpos[2] != 4503) begin failures++; $display("FAIL cont_valid_pos got=%0d,%0d,%0d exp=1501,3002,4503", vpos[0], vpos[1], vpos[2]); end
  endtask

  task automatic test_back_to_back();
    int at;
    int extra = 0;
    p_r = 10; p_g = 20; p_b = 25;
    do_start();
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(301, 1700, at);
    checks++; if (at < 1501 || at > 1502) begin failures++; $display("FAIL b2b_latency got=%0d exp=1501..1502", at); end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (valid === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL b2b_extra_valid got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int vcnt = 0;
    p_r = 10; p_g = 20; p_b = 25;
    do_start();
    repeat (700) @(negedge clk);
    checks++; if (filter !== 2'b00) begin failures++; $display("FAIL mid_pre_filter got=%b exp=00", filter); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (filter !== 2'b10 || busy !== 1'b0) begin failures++; $display("FAIL mid_state got filter=%b busy=%b exp 10/0", filter, busy); end
    checks++; if (color !== 2'd0 || overflow !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL mid_outputs got color=%0d ovf=%b valid=%b exp 0/0/0", color, overflow, valid); end
    checks++; if ({red_count, green_count, blue_count} !== 24'd0) begin failures++; $display("FAIL mid_counts got=%0d/%0d/%0d exp=0", red_count, green_count, blue_count); end
    rst_n = 1'b1;
    for (int n = 0; n < 1700; n++) begin
      @(negedge clk);
      if (valid === 1'b1) vcnt++;
    end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL mid_no_valid got=%0d exp=0", vcnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; start4 = 1'b0;
    test_reset();
    test_red();
    test_green();
    test_blue();
    test_tie();
    test_none();
    test_overflow();
    test_back_to_back();
    test_continuous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcs3200_color_classifier.md
TCS3200_COLOR_CLASSIFIER -- requirements
Module: tcs3200_color_classifier

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 500, meaning clk_1MHz cycles per filter phase (minimum 8).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 100, meaning counting window at the end of each phase (1..PHASE_CYCLES-4).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of each channel count.
REQ-004 SHALL have parameter MIN_COUNT, default 2, meaning minimum winning count for a valid colour.
REQ-005 SHALL have port clk_1MHz, input, 1, the single clock (1 MHz).
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port cs_out, input, 1, asynchronous TCS3200 frequency output.
REQ-008 SHALL have port start, input, 1, one-cycle request to begin a measurement sequence.
REQ-009 SHALL have port continuous, input, 1, 1 = restart sequence automatically after each decision.
REQ-010 SHALL have port filter, output, 2, S2S3 select: 00 red, 01 blue, 10 clear/idle, 11 green.
REQ-011 SHALL have port color, output, 2, result: 0 none, 1 red, 2 green, 3 blue.
REQ-012 SHALL have ports red_count, green_count, blue_count, output, CNT_W each, latched window counts.
REQ-013 SHALL have port valid, output, 1, one-cycle pulse when color and counts update.
REQ-014 SHALL have ports busy (1 while measuring) and overflow (1 if any count of the last result saturated), outputs, 1 each.

Function
REQ-015 SHALL pass cs_out through a 2-flop synchroniser plus rising-edge detector; the detect pulse occurs 3 cycles after the edge.
REQ-016 SHALL use states IDLE, MEAS_G, MEAS_R, MEAS_B, DECIDE, with filter driven 10, 11, 00, 01, 10 respectively.
REQ-017 SHALL move IDLE->MEAS_G on start=1; start is ignored in every other state.
REQ-018 SHALL hold each MEAS state exactly PHASE_CYCLES cycles, tracked by a phase counter running 0..PHASE_CYCLES-1, then advance G->R->B->DECIDE.
REQ-019 SHALL count only detect pulses with phase counter >= PHASE_CYCLES-WINDOW_CYCLES, which excludes filter settling time.
REQ-020 SHALL saturate the window counter at 2^CNT_W-1 and record a per-sequence saturation flag.
REQ-021 SHALL latch the window count into the phase's channel register on the last phase cycle, including a pulse detected in that same cycle, then clear the counter.
REQ-022 SHALL spend one cycle in DECIDE: select the maximum channel, with ties resolved red > green > blue; color = 0 if that maximum < MIN_COUNT.
REQ-023 SHALL update color, the three counts and overflow in DECIDE, with valid asserted during the cycle after DECIDE.
REQ-024 SHALL go DECIDE->MEAS_G if continuous=1, sampled in DECIDE, else DECIDE->IDLE.
REQ-025 SHALL hold color and counts stable between valid pulses; busy = 1 in MEAS_* and DECIDE.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge in any state, enter IDLE with filter=10, color=0, counts=0, valid=0, busy=0, overflow=0, synchroniser and counters cleared.
REQ-027 SHALL discard a partially measured sequence on reset mid-operation and produce no valid pulse for it.

Structure
REQ-028 SHALL place filter encodings, colour codes and the state enum in shared package tcs3200_pkg.
REQ-029 SHALL implement synchroniser plus edge detect as sub-module cs_edge_sync.

Verification (defaults)
REQ-030 SHALL cover: start, cs_out period red 10 us / green 20 us / blue 25 us -> counts 10/5/4 (+-1), color=1, valid once at 1501-1502 cycles after start.
REQ-031 SHALL cover: green 8 us, others 50 us -> color=2; blue 5 us, others 40 us -> color=3.
REQ-032 SHALL cover: red=green=12 counts, blue=3 -> color=1 (tie rule); all periods 100 us (1 count each) -> color=0.
REQ-033 SHALL cover: CNT_W=4 with cs_out period 2 us -> counts 15, overflow=1.
REQ-034 SHALL cover: continuous=1 -> valid every 1501 cycles and filter sequence 11,00,01,10 repeating; continuous dropped -> IDLE after next DECIDE.
REQ-035 SHALL cover: rst_n=0 during MEAS_R -> IDLE, outputs at reset values, no valid; start during busy ignored.
